// File: rtl/mem_stall_shim.sv
`default_nettype none
// ============================================================================
// Module   : mem_stall_shim
// Purpose  : Single-outstanding memory request shim. Holds each core request
//            for an LFSR-chosen number of stall cycles, issues it to a
//            one-cycle-latency SRAM and returns the read data. Every value
//            carries a _t0 taint shadow; stall timing inherits the taint of
//            the request and of the stall enable.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stall_shim #(
  parameter int          AddrWidth = 32,
  parameter int          DataWidth = 32,
  parameter int          MaxStall  = 7,
  parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_en_i,
  input  logic                   stall_en_i_t0,
  input  logic                   req_i,
  input  logic                   req_i_t0,
  input  logic                   we_i,
  input  logic                   we_i_t0,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [AddrWidth-1:0]   addr_i_t0,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth-1:0]   wdata_i_t0,
  input  logic [DataWidth/8-1:0] strb_i,
  input  logic [DataWidth/8-1:0] strb_i_t0,
  output logic                   gnt_o,
  output logic                   gnt_o_t0,
  output logic                   rvalid_o,
  output logic                   rvalid_o_t0,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [DataWidth-1:0]   rdata_o_t0,
  output logic                   mem_req_o,
  output logic                   mem_req_o_t0,
  output logic                   mem_we_o,
  output logic                   mem_we_o_t0,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [AddrWidth-1:0]   mem_addr_o_t0,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth-1:0]   mem_wdata_o_t0,
  output logic [DataWidth/8-1:0] mem_strb_o,
  output logic [DataWidth/8-1:0] mem_strb_o_t0,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic [DataWidth-1:0]   mem_rdata_i_t0
);

  // Stall counter must hold 0..MaxStall; keep at least one bit when stalling is off.
  localparam int         c_cnt_width = (MaxStall < 1) ? 1 : $clog2(MaxStall + 1);
  localparam logic [8:0] c_stall_mod = 9'(MaxStall + 1);
  localparam int         c_strb_width = DataWidth / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_cnt_width-1:0]  r_cnt;
  logic [c_cnt_width-1:0]  w_cnt_next;
  logic [c_cnt_width-1:0]  w_stall_cnt;
  logic                    w_capture;
  logic [15:0]             r_lfsr;

  logic                    r_we;
  logic                    r_we_t0;
  logic [AddrWidth-1:0]    r_addr;
  logic [AddrWidth-1:0]    r_addr_t0;
  logic [DataWidth-1:0]    r_wdata;
  logic [DataWidth-1:0]    r_wdata_t0;
  logic [c_strb_width-1:0] r_strb;
  logic [c_strb_width-1:0] r_strb_t0;
  logic                    r_tt;

  // Stall length drawn from the low LFSR byte, only when stalling is enabled.
  assign w_stall_cnt = stall_en_i ? c_cnt_width'({1'b0, r_lfsr[7:0]} % c_stall_mod)
                                  : '0;

  // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1), independent of the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= LfsrSeed;
    end else begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  // FSM state and stall counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request capture; fields and their taints are only ever forwarded from here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_we_t0    <= 1'b0;
      r_addr     <= '0;
      r_addr_t0  <= '0;
      r_wdata    <= '0;
      r_wdata_t0 <= '0;
      r_strb     <= '0;
      r_strb_t0  <= '0;
      r_tt       <= 1'b0;
    end else if (w_capture) begin
      r_we       <= we_i;
      r_we_t0    <= we_i_t0;
      r_addr     <= addr_i;
      r_addr_t0  <= addr_i_t0;
      r_wdata    <= wdata_i;
      r_wdata_t0 <= wdata_i_t0;
      r_strb     <= strb_i;
      r_strb_t0  <= strb_i_t0;
      r_tt       <= req_i_t0 | stall_en_i_t0;
    end
  end

  // Next-state logic and Moore outputs; everything idles at zero.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_capture      = 1'b0;
    gnt_o          = 1'b0;
    gnt_o_t0       = 1'b0;
    rvalid_o       = 1'b0;
    rvalid_o_t0    = 1'b0;
    rdata_o        = '0;
    rdata_o_t0     = '0;
    mem_req_o      = 1'b0;
    mem_req_o_t0   = 1'b0;
    mem_we_o       = 1'b0;
    mem_we_o_t0    = 1'b0;
    mem_addr_o     = '0;
    mem_addr_o_t0  = '0;
    mem_wdata_o    = '0;
    mem_wdata_o_t0 = '0;
    mem_strb_o     = '0;
    mem_strb_o_t0  = '0;

    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          w_capture    = 1'b1;
          w_cnt_next   = w_stall_cnt;
          w_state_next = (w_stall_cnt != '0) ? ST_STALL : ST_ISSUE;
        end
      end
      ST_STALL: begin
        w_cnt_next = r_cnt - c_cnt_width'(1);
        if (r_cnt <= c_cnt_width'(1)) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gnt_o          = 1'b1;
        gnt_o_t0       = r_tt;
        mem_req_o      = 1'b1;
        mem_req_o_t0   = r_tt;
        mem_we_o       = r_we;
        mem_we_o_t0    = r_we_t0;
        mem_addr_o     = r_addr;
        mem_addr_o_t0  = r_addr_t0;
        mem_wdata_o    = r_wdata;
        mem_wdata_o_t0 = r_wdata_t0;
        mem_strb_o     = r_strb;
        mem_strb_o_t0  = r_strb_t0;
        w_state_next   = ST_RESP;
      end
      ST_RESP: begin
        rvalid_o     = 1'b1;
        rvalid_o_t0  = r_tt;
        rdata_o      = mem_rdata_i;
        rdata_o_t0   = mem_rdata_i_t0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_shim.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stall_shim
// Purpose  : Self-checking bench for mem_stall_shim: cycle-by-cycle compare
//            against a transaction-level latency model, plus directed cases
//            with hand-computed results. A second instance runs MaxStall=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stall_shim;

  localparam int          MAXS = 7;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_en = 1'b0, stall_en_t0 = 1'b0, req = 1'b0, req_t0 = 1'b0;
  logic        we = 1'b0, we_t0 = 1'b0;
  logic [31:0] addr = '0, addr_t0 = '0, wdata = '0, wdata_t0 = '0;
  logic [3:0]  strb = '0, strb_t0 = '0;

  logic        gnt, gnt_t0, rvalid, rvalid_t0;
  logic [31:0] rdata, rdata_t0;
  logic        mem_req, mem_req_t0, mem_we, mem_we_t0;
  logic [31:0] mem_addr, mem_addr_t0, mem_wdata, mem_wdata_t0;
  logic [3:0]  mem_strb, mem_strb_t0;
  logic [31:0] mem_rdata, mem_rdata_t0;

  // Second instance (MaxStall = 0) with its own request and a fixed SRAM word.
  logic        req0 = 1'b0;
  logic        one = 1'b1;
  logic [31:0] z_mem_rdata = 32'h5A5A5A5A;
  logic [31:0] z_mem_rdata_t0 = 32'h0;
  logic        z_gnt, z_gnt_t0, z_rvalid, z_rvalid_t0;
  logic [31:0] z_rdata, z_rdata_t0;
  logic        z_mem_req, z_mem_req_t0, z_mem_we, z_mem_we_t0;
  logic [31:0] z_mem_addr, z_mem_addr_t0, z_mem_wdata, z_mem_wdata_t0;
  logic [3:0]  z_mem_strb, z_mem_strb_t0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_stall_shim #(.AddrWidth(32), .DataWidth(32), .MaxStall(MAXS), .LfsrSeed(SEED)) dut (
    .clk_i(clk), .rst_i(rst),
    .stall_en_i(stall_en), .stall_en_i_t0(stall_en_t0),
    .req_i(req), .req_i_t0(req_t0), .we_i(we), .we_i_t0(we_t0),
    .addr_i(addr), .addr_i_t0(addr_t0), .wdata_i(wdata), .wdata_i_t0(wdata_t0),
    .strb_i(strb), .strb_i_t0(strb_t0),
    .gnt_o(gnt), .gnt_o_t0(gnt_t0), .rvalid_o(rvalid), .rvalid_o_t0(rvalid_t0),
    .rdata_o(rdata), .rdata_o_t0(rdata_t0),
    .mem_req_o(mem_req), .mem_req_o_t0(mem_req_t0), .mem_we_o(mem_we), .mem_we_o_t0(mem_we_t0),
    .mem_addr_o(mem_addr), .mem_addr_o_t0(mem_addr_t0),
    .mem_wdata_o(mem_wdata), .mem_wdata_o_t0(mem_wdata_t0),
    .mem_strb_o(mem_strb), .mem_strb_o_t0(mem_strb_t0),
    .mem_rdata_i(mem_rdata), .mem_rdata_i_t0(mem_rdata_t0)
  );

  mem_stall_shim #(.AddrWidth(32), .DataWidth(32), .MaxStall(0), .LfsrSeed(SEED)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .stall_en_i(one), .stall_en_i_t0(stall_en_t0),
    .req_i(req0), .req_i_t0(req_t0), .we_i(we), .we_i_t0(we_t0),
    .addr_i(addr), .addr_i_t0(addr_t0), .wdata_i(wdata), .wdata_i_t0(wdata_t0),
    .strb_i(strb), .strb_i_t0(strb_t0),
    .gnt_o(z_gnt), .gnt_o_t0(z_gnt_t0), .rvalid_o(z_rvalid), .rvalid_o_t0(z_rvalid_t0),
    .rdata_o(z_rdata), .rdata_o_t0(z_rdata_t0),
    .mem_req_o(z_mem_req), .mem_req_o_t0(z_mem_req_t0), .mem_we_o(z_mem_we), .mem_we_o_t0(z_mem_we_t0),
    .mem_addr_o(z_mem_addr), .mem_addr_o_t0(z_mem_addr_t0),
    .mem_wdata_o(z_mem_wdata), .mem_wdata_o_t0(z_mem_wdata_t0),
    .mem_strb_o(z_mem_strb), .mem_strb_o_t0(z_mem_strb_t0),
    .mem_rdata_i(z_mem_rdata), .mem_rdata_i_t0(z_mem_rdata_t0)
  );

  // One-cycle-latency SRAM with a taint plane; returns the old word on writes.
  logic [31:0] ram    [64];
  logic [31:0] ram_t0 [64];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) begin
        ram[i]    <= 32'h0;
        ram_t0[i] <= 32'h0;
      end
      ram[4]       <= 32'hDEADBEEF;
      ram[8]       <= 32'h0BADF00D;
      ram[16]      <= 32'hAAAAAAAA;
      mem_rdata    <= 32'h0;
      mem_rdata_t0 <= 32'h0;
      loaded       <= 1'b1;
    end else if (mem_req) begin
      mem_rdata    <= ram[mem_addr[7:2]];
      mem_rdata_t0 <= ram_t0[mem_addr[7:2]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_strb[b]) begin
            ram[mem_addr[7:2]][8*b +: 8]    <= mem_wdata[8*b +: 8];
            ram_t0[mem_addr[7:2]][8*b +: 8] <= mem_wdata_t0[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: each accepted request is scheduled to be granted
  // 1+N cycles later and answered one cycle after that; nothing new is accepted
  // until the answer cycle has passed.
  int          m_issue = -1, m_resp = -1;
  bit          m_live = 1'b0;
  logic [15:0] m_lfsr = 16'h0;
  logic        m_we = 1'b0, m_we_t0 = 1'b0, m_tt = 1'b0;
  logic [31:0] m_addr = '0, m_addr_t0 = '0, m_wdata = '0, m_wdata_t0 = '0;
  logic [3:0]  m_strb = '0, m_strb_t0 = '0;

  initial begin
    int  n;
    bit  e_iss, e_rsp;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_live  = 1'b1;
        m_issue = -1;
        m_resp  = -1;
        m_lfsr  = SEED;
      end else begin
        if (req && cyc > m_resp) begin
          n = stall_en ? (int'(m_lfsr[7:0]) % (MAXS + 1)) : 0;
          m_issue    = cyc + 1 + n;
          m_resp     = m_issue + 1;
          m_we       = we;     m_we_t0    = we_t0;
          m_addr     = addr;   m_addr_t0  = addr_t0;
          m_wdata    = wdata;  m_wdata_t0 = wdata_t0;
          m_strb     = strb;   m_strb_t0  = strb_t0;
          m_tt       = req_t0 | stall_en_t0;
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
      cyc++;
      #1;
      if (m_live) begin
        e_iss = (cyc == m_issue);
        e_rsp = (cyc == m_resp);
        chk("handshake", {gnt, gnt_t0, mem_req, mem_req_t0, rvalid, rvalid_t0},
            {e_iss, e_iss & m_tt, e_iss, e_iss & m_tt, e_rsp, e_rsp & m_tt});
        chk("mem_ctl", {mem_we, mem_we_t0, mem_strb, mem_strb_t0},
            e_iss ? {m_we, m_we_t0, m_strb, m_strb_t0} : 10'd0);
        chk("mem_addr", {mem_addr_t0, mem_addr}, e_iss ? {m_addr_t0, m_addr} : 64'd0);
        chk("mem_wdata", {mem_wdata_t0, mem_wdata}, e_iss ? {m_wdata_t0, m_wdata} : 64'd0);
        chk("rdata", {rdata_t0, rdata}, e_rsp ? {mem_rdata_t0, mem_rdata} : 64'd0);
      end
    end
  end

  // Values seen at the grant / response of the last directed transaction.
  logic        s_we, s_gnt_t0, s_req_t0, s_rvalid_t0;
  logic [3:0]  s_strb;
  logic [31:0] s_addr, s_wdata_t0, s_rdata, s_rdata_t0;

  // Issue one request at a negedge in IDLE; latencies count cycles after it.
  // Fields and the stall enable are disturbed once the request is captured.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] dt0,
                     output int glat, output int rlat);
    logic se, se_t0;
    se = stall_en; se_t0 = stall_en_t0;
    we = w; addr = a; wdata = d; strb = s; wdata_t0 = dt0; req = 1'b1;
    glat = -1; rlat = -1;
    for (int k = 1; k <= 40 && rlat < 0; k++) begin
      @(negedge clk);
      if (gnt && glat < 0) begin
        glat = k; req = 1'b0;
        s_we = mem_we; s_strb = mem_strb; s_addr = mem_addr; s_wdata_t0 = mem_wdata_t0;
        s_gnt_t0 = gnt_t0; s_req_t0 = mem_req_t0;
      end
      if (rvalid) begin
        rlat = k; s_rdata = rdata; s_rdata_t0 = rdata_t0; s_rvalid_t0 = rvalid_t0;
      end
      if (k == 1) begin
        we = 1'b0; addr = '0; addr_t0 = '0; wdata = '0; wdata_t0 = '0; strb = '0;
        stall_en = ~se; stall_en_t0 = ~se_t0;
      end
    end
    req = 1'b0; stall_en = se; stall_en_t0 = se_t0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, r, g0, r0, gcount, gap_bad, glast;
    logic [31:0] z_addr_seen, z_rdata_seen;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt, gnt_t0, rvalid, rvalid_t0, mem_req, mem_req_t0, rdata}, 64'd0);

    // Seed LFSR 0xACE1: 0xE1 % 8 = 1 stall cycle.
    rst = 1'b0; stall_en = 1'b1;
    txn(1'b0, 32'h8000_0020, 32'h0, 4'hF, 32'h0, g, r);
    chk("seed_gnt_lat", g, 2);
    chk("seed_rvalid_lat", r, 3);
    chk("seed_rdata", s_rdata, 32'h0BADF00D);
    @(negedge clk);
    addr_t0 = 32'h0000_F000;
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'h0, g, r);
    chk("second_rdata", s_rdata, 32'hDEADBEEF);

    // No stalls: fixed latency 1 / 2.
    stall_en = 1'b0;
    @(negedge clk);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'h0, g, r);
    chk("nostall_gnt_lat", g, 1);
    chk("nostall_rvalid_lat", r, 2);
    chk("nostall_addr", s_addr, 32'h8000_0010);
    chk("nostall_rdata", s_rdata, 32'hDEADBEEF);
    chk("nostall_taints", {s_gnt_t0, s_req_t0, s_rvalid_t0, s_rdata_t0}, 35'd0);

    // Partial write with tainted low byte, then read it back.
    @(negedge clk);
    txn(1'b1, 32'h8000_0040, 32'h1234_5678, 4'b0011, 32'h0000_00FF, g, r);
    chk("write_we_strb", {s_we, s_strb}, 5'b1_0011);
    chk("write_wdata_t0", s_wdata_t0, 32'h0000_00FF);
    @(negedge clk);
    txn(1'b0, 32'h8000_0040, 32'h0, 4'hF, 32'h0, g, r);
    chk("readback_rdata", s_rdata, 32'hAAAA_5678);
    chk("readback_rdata_t0", s_rdata_t0, 32'h0000_00FF);

    // Tainted stall enable taints handshake timing only.
    stall_en_t0 = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'h0, g, r);
    chk("sten_t0_handshake", {s_gnt_t0, s_req_t0, s_rvalid_t0}, 3'b111);
    chk("sten_t0_rdata_t0", s_rdata_t0, 32'h0);
    stall_en_t0 = 1'b0; req_t0 = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'h0, g, r);
    chk("req_t0_gnt_t0", s_gnt_t0, 1'b1);
    req_t0 = 1'b0;

    // Reset during STALL drops the request; next request sees the seed again.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall_en = 1'b1; req = 1'b1; addr = 32'h8000_0020;
    @(negedge clk);
    chk("stall_no_gnt", gnt, 1'b0);
    rst = 1'b1; req = 1'b0; addr = '0;
    @(negedge clk);
    chk("post_rst_outputs", {gnt, rvalid, mem_req, mem_addr, rdata}, 67'd0);
    rst = 1'b0;
    txn(1'b0, 32'h8000_0020, 32'h0, 4'hF, 32'h0, g, r);
    chk("post_rst_gnt_lat", g, 2);
    chk("post_rst_rvalid_lat", r, 3);
    chk("post_rst_rdata", s_rdata, 32'h0BADF00D);
    stall_en = 1'b0;

    // Held request without stalls: a grant every third cycle.
    @(negedge clk);
    req = 1'b1; addr = 32'h8000_0010;
    gcount = 0; gap_bad = 0; glast = -2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (gnt) begin
        gcount++;
        if (k - glast != 3) gap_bad++;
        glast = k;
      end
    end
    req = 1'b0; addr = '0;
    chk("held_gnt_count", gcount, 4);
    chk("held_gnt_gaps", gap_bad, 0);

    // MaxStall = 0 instance: stall enable has no effect.
    @(negedge clk);
    addr = 32'h8000_0030; req0 = 1'b1;
    g0 = -1; r0 = -1; z_addr_seen = '0; z_rdata_seen = '0;
    for (int k = 1; k <= 10 && r0 < 0; k++) begin
      @(negedge clk);
      if (z_gnt && g0 < 0) begin
        g0 = k; req0 = 1'b0; z_addr_seen = z_mem_addr;
      end
      if (z_rvalid) begin
        r0 = k; z_rdata_seen = z_rdata;
      end
    end
    req0 = 1'b0; addr = '0;
    chk("max0_gnt_lat", g0, 1);
    chk("max0_rvalid_lat", r0, 2);
    chk("max0_addr", z_addr_seen, 32'h8000_0030);
    chk("max0_rdata", z_rdata_seen, 32'h5A5A5A5A);
    @(negedge clk);
    chk("max0_idle", |{z_gnt, z_gnt_t0, z_rvalid, z_rvalid_t0, z_rdata, z_rdata_t0,
                       z_mem_req, z_mem_req_t0, z_mem_we, z_mem_we_t0,
                       z_mem_addr, z_mem_addr_t0, z_mem_wdata, z_mem_wdata_t0,
                       z_mem_strb, z_mem_strb_t0}, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
